// File: rtl/fios_result_collector.sv
// Collects LSW-first FIOS Montgomery result words, optionally applies the final
// conditional subtraction (macro FIOS_FINAL_SUB_EN), and streams the result out.
//
// state    | meaning
// IDLE     | waiting for the first result word
// COLLECT  | capturing words into T; one extra cycle once the buffer is full
// SUBTRACT | word-serial T - p with a one-cycle modulus read latency
// OUTPUT   | streaming the selected buffer through valid/ready
module fios_result_collector #(
   parameter int WORD_WIDTH = 17,
   parameter int WORD_COUNT = 16,
   parameter int IDX_WIDTH  = $clog2(WORD_COUNT)
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  res_valid_i,
   input  logic [WORD_WIDTH-1:0] res_i,
   output logic [IDX_WIDTH-1:0]  p_addr_o,
   input  logic [WORD_WIDTH-1:0] p_word_i,
   output logic                  result_valid_o,
   input  logic                  result_ready_i,
   output logic [WORD_WIDTH-1:0] result_o,
   output logic                  result_last_o,
   output logic                  busy_o,
   output logic                  error_o
);

   if (WORD_COUNT < 2) begin : g_bad_word_count
      $error("fios_result_collector: WORD_COUNT must be >= 2");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_SUBTRACT,
      ST_OUTPUT
   } state_t;

   localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(WORD_COUNT - 1);

   state_t                state_q, state_d;
   logic [IDX_WIDTH-1:0]  idx_q, idx_d;
   logic                  full_q, full_d;
   logic                  error_q, error_d;
   logic [WORD_WIDTH-1:0] t_q [WORD_COUNT];
   logic [WORD_WIDTH-1:0] t_d [WORD_COUNT];

`ifdef FIOS_FINAL_SUB_EN
   localparam logic [IDX_WIDTH:0] SUB_LAST = (IDX_WIDTH+1)'(WORD_COUNT);

   logic [IDX_WIDTH:0]    sub_cnt_q, sub_cnt_d;
   logic                  borrow_q, borrow_d;
   logic                  sel_d_q, sel_d_d;
   logic [WORD_WIDTH-1:0] d_q [WORD_COUNT];
   logic [WORD_WIDTH-1:0] d_d [WORD_COUNT];
   logic [WORD_WIDTH:0]   sub_diff;
   logic [IDX_WIDTH-1:0]  sub_idx;

   // The word being subtracted lags the issued modulus address by one cycle.
   assign sub_idx = IDX_WIDTH'(sub_cnt_q - 1'b1);
`else
   logic unused_p_word;

   assign unused_p_word = ^p_word_i;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      full_d  = full_q;
      error_d = error_q;
      t_d     = t_q;
`ifdef FIOS_FINAL_SUB_EN
      sub_cnt_d = sub_cnt_q;
      borrow_d  = borrow_q;
      sel_d_d   = sel_d_q;
      d_d       = d_q;
      sub_diff  = '0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (res_valid_i) begin
               t_d[0]  = res_i;
               idx_d   = IDX_WIDTH'(1);
               full_d  = 1'b0;
               state_d = ST_COLLECT;
            end
         end

         ST_COLLECT: begin
            if (full_q) begin
               // Buffer is already full: a word arriving here cannot be stored.
               if (res_valid_i) error_d = 1'b1;
               full_d = 1'b0;
`ifdef FIOS_FINAL_SUB_EN
               sub_cnt_d = '0;
               borrow_d  = 1'b0;
               state_d   = ST_SUBTRACT;
`else
               state_d   = ST_OUTPUT;
`endif
            end else if (res_valid_i) begin
               t_d[idx_q] = res_i;
               if (idx_q == IDX_LAST) begin
                  idx_d  = '0;
                  full_d = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

`ifdef FIOS_FINAL_SUB_EN
         ST_SUBTRACT: begin
            if (res_valid_i) error_d = 1'b1;
            sub_cnt_d = sub_cnt_q + 1'b1;
            if (sub_cnt_q != '0) begin
               sub_diff = {1'b0, t_q[sub_idx]} - {1'b0, p_word_i}
                          - {{WORD_WIDTH{1'b0}}, borrow_q};
               d_d[sub_idx] = sub_diff[WORD_WIDTH-1:0];
               borrow_d     = sub_diff[WORD_WIDTH];
               if (sub_cnt_q == SUB_LAST) begin
                  sel_d_d   = ~sub_diff[WORD_WIDTH];
                  sub_cnt_d = '0;
                  idx_d     = '0;
                  state_d   = ST_OUTPUT;
               end
            end
         end
`endif

         ST_OUTPUT: begin
            if (res_valid_i) error_d = 1'b1;
            if (result_ready_i) begin
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         full_q  <= 1'b0;
         error_q <= 1'b0;
`ifdef FIOS_FINAL_SUB_EN
         sub_cnt_q <= '0;
         borrow_q  <= 1'b0;
         sel_d_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         full_q  <= full_d;
         error_q <= error_d;
`ifdef FIOS_FINAL_SUB_EN
         sub_cnt_q <= sub_cnt_d;
         borrow_q  <= borrow_d;
         sel_d_q   <= sel_d_d;
`endif
      end
   end

   // Buffer contents are meaningless until refilled, so they carry no reset.
   always_ff @(posedge clock_i) begin
      t_q <= t_d;
`ifdef FIOS_FINAL_SUB_EN
      d_q <= d_d;
`endif
   end

   always_comb begin
      result_valid_o = (state_q == ST_OUTPUT);
      result_last_o  = (state_q == ST_OUTPUT) && (idx_q == IDX_LAST);
      busy_o         = (state_q != ST_IDLE);
      error_o        = error_q;
      result_o       = '0;
      p_addr_o       = '0;
      if (state_q == ST_OUTPUT) begin
`ifdef FIOS_FINAL_SUB_EN
         result_o = sel_d_q ? d_q[idx_q] : t_q[idx_q];
`else
         result_o = t_q[idx_q];
`endif
      end
`ifdef FIOS_FINAL_SUB_EN
      if ((state_q == ST_SUBTRACT) && (sub_cnt_q < SUB_LAST)) begin
         p_addr_o = sub_cnt_q[IDX_WIDTH-1:0];
      end
`endif
   end

endmodule
